// File: rtl/sb_arb2.sv
// sb_arb2: two-master / one-slave arbiter for the simple bus (m0 = data, m1 = fetch).
// Latency: one bubble cycle per grant (the IDLE cycle that registers the grant); one transaction in flight.
// Backpressure: slave readies and valids pass straight through; stalled rready/bready hold state and grant.
// Optional: define SB_ARB_RR_EN for round-robin arbitration (default build is fixed priority, m0 wins).
module sb_arb2 #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  // master 0
  input  logic            sb_arvalid_m0,
  input  logic [AW-1:0]   sb_araddr_m0,
  output logic            sb_arready_m0,
  output logic            sb_rvalid_m0,
  output logic [DW-1:0]   sb_rdata_m0,
  input  logic            sb_rready_m0,
  input  logic            sb_wvalid_m0,
  input  logic [AW-1:0]   sb_waddr_m0,
  input  logic [DW-1:0]   sb_wdata_m0,
  input  logic [DW/8-1:0] sb_wstrb_m0,
  output logic            sb_wready_m0,
  output logic            sb_bvalid_m0,
  output logic            sb_bresp_m0,
  input  logic            sb_bready_m0,
  // master 1
  input  logic            sb_arvalid_m1,
  input  logic [AW-1:0]   sb_araddr_m1,
  output logic            sb_arready_m1,
  output logic            sb_rvalid_m1,
  output logic [DW-1:0]   sb_rdata_m1,
  input  logic            sb_rready_m1,
  input  logic            sb_wvalid_m1,
  input  logic [AW-1:0]   sb_waddr_m1,
  input  logic [DW-1:0]   sb_wdata_m1,
  input  logic [DW/8-1:0] sb_wstrb_m1,
  output logic            sb_wready_m1,
  output logic            sb_bvalid_m1,
  output logic            sb_bresp_m1,
  input  logic            sb_bready_m1,
  // slave
  output logic            sb_arvalid_s,
  output logic [AW-1:0]   sb_araddr_s,
  input  logic            sb_arready_s,
  input  logic            sb_rvalid_s,
  input  logic [DW-1:0]   sb_rdata_s,
  output logic            sb_rready_s,
  output logic            sb_wvalid_s,
  output logic [AW-1:0]   sb_waddr_s,
  output logic [DW-1:0]   sb_wdata_s,
  output logic [DW/8-1:0] sb_wstrb_s,
  input  logic            sb_wready_s,
  input  logic            sb_bvalid_s,
  input  logic            sb_bresp_s,
  output logic            sb_bready_s,
  // registered one-hot grant: bit0 = m0, bit1 = m1
  output logic [1:0]      sb_gnt
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_W    = 3'd3,
    ST_B    = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;
  logic [1:0] gnt_nxt;

  logic req0;
  logic req1;
  logic win_m1;
  logic win_arvalid;

  assign req0 = sb_arvalid_m0 | sb_wvalid_m0;
  assign req1 = sb_arvalid_m1 | sb_wvalid_m1;

  // Inputs of the currently granted master (only meaningful outside IDLE).
  logic            g_arvalid;
  logic [AW-1:0]   g_araddr;
  logic            g_rready;
  logic            g_wvalid;
  logic [AW-1:0]   g_waddr;
  logic [DW-1:0]   g_wdata;
  logic [DW/8-1:0] g_wstrb;
  logic            g_bready;

  assign g_arvalid = sb_gnt[1] ? sb_arvalid_m1 : sb_arvalid_m0;
  assign g_araddr  = sb_gnt[1] ? sb_araddr_m1  : sb_araddr_m0;
  assign g_rready  = sb_gnt[1] ? sb_rready_m1  : sb_rready_m0;
  assign g_wvalid  = sb_gnt[1] ? sb_wvalid_m1  : sb_wvalid_m0;
  assign g_waddr   = sb_gnt[1] ? sb_waddr_m1   : sb_waddr_m0;
  assign g_wdata   = sb_gnt[1] ? sb_wdata_m1   : sb_wdata_m0;
  assign g_wstrb   = sb_gnt[1] ? sb_wstrb_m1   : sb_wstrb_m0;
  assign g_bready  = sb_gnt[1] ? sb_bready_m1  : sb_bready_m0;

`ifdef SB_ARB_RR_EN
  // last_gnt = 1 means m1 held the previous grant; reset value lets m0 win first.
  logic last_gnt;

  // Winner selection: on contention favour the master not granted last.
  always_comb begin
    win_m1 = req1 & (~req0 | ~last_gnt);
  end

  // Remember which master took each grant issued from IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= 1'b1;
    end else if (state == ST_IDLE && (req0 | req1)) begin
      last_gnt <= win_m1;
    end
  end
`else
  // Winner selection: fixed priority, m0 always wins on contention.
  always_comb begin
    win_m1 = req1 & ~req0;
  end
`endif

  // State and grant registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      sb_gnt <= 2'b00;
    end else begin
      state  <= state_nxt;
      sb_gnt <= gnt_nxt;
    end
  end

  // Next-state logic; a read is preferred when the winner offers both channels.
  always_comb begin
    state_nxt   = state;
    gnt_nxt     = sb_gnt;
    win_arvalid = win_m1 ? sb_arvalid_m1 : sb_arvalid_m0;
    case (state)
      ST_IDLE: begin
        if (req0 | req1) begin
          gnt_nxt   = win_m1 ? 2'b10 : 2'b01;
          state_nxt = win_arvalid ? ST_AR : ST_W;
        end
      end
      ST_AR: begin
        if (!g_arvalid) begin
          state_nxt = ST_IDLE;
          gnt_nxt   = 2'b00;
        end else if (sb_arready_s) begin
          state_nxt = ST_R;
        end
      end
      ST_R: begin
        if (sb_rvalid_s && g_rready) begin
          state_nxt = ST_IDLE;
          gnt_nxt   = 2'b00;
        end
      end
      ST_W: begin
        if (!g_wvalid) begin
          state_nxt = ST_IDLE;
          gnt_nxt   = 2'b00;
        end else if (sb_wready_s) begin
          state_nxt = ST_B;
        end
      end
      ST_B: begin
        if (sb_bvalid_s && g_bready) begin
          state_nxt = ST_IDLE;
          gnt_nxt   = 2'b00;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        gnt_nxt   = 2'b00;
      end
    endcase
  end

  // Channel muxes: only the active phase and granted master see valid/ready.
  always_comb begin
    sb_arvalid_s  = 1'b0;
    sb_araddr_s   = '0;
    sb_rready_s   = 1'b0;
    sb_wvalid_s   = 1'b0;
    sb_waddr_s    = '0;
    sb_wdata_s    = '0;
    sb_wstrb_s    = '0;
    sb_bready_s   = 1'b0;
    sb_arready_m0 = 1'b0;
    sb_arready_m1 = 1'b0;
    sb_rvalid_m0  = 1'b0;
    sb_rvalid_m1  = 1'b0;
    sb_wready_m0  = 1'b0;
    sb_wready_m1  = 1'b0;
    sb_bvalid_m0  = 1'b0;
    sb_bvalid_m1  = 1'b0;
    // read data and write response are broadcast; only the valids are steered
    sb_rdata_m0   = sb_rdata_s;
    sb_rdata_m1   = sb_rdata_s;
    sb_bresp_m0   = sb_bresp_s;
    sb_bresp_m1   = sb_bresp_s;
    case (state)
      ST_AR: begin
        sb_arvalid_s  = g_arvalid;
        sb_araddr_s   = g_araddr;
        sb_arready_m0 = sb_gnt[0] & sb_arready_s;
        sb_arready_m1 = sb_gnt[1] & sb_arready_s;
      end
      ST_R: begin
        sb_rready_s  = g_rready;
        sb_rvalid_m0 = sb_gnt[0] & sb_rvalid_s;
        sb_rvalid_m1 = sb_gnt[1] & sb_rvalid_s;
      end
      ST_W: begin
        sb_wvalid_s  = g_wvalid;
        sb_waddr_s   = g_waddr;
        sb_wdata_s   = g_wdata;
        sb_wstrb_s   = g_wstrb;
        sb_wready_m0 = sb_gnt[0] & sb_wready_s;
        sb_wready_m1 = sb_gnt[1] & sb_wready_s;
      end
      ST_B: begin
        sb_bready_s  = g_bready;
        sb_bvalid_m0 = sb_gnt[0] & sb_bvalid_s;
        sb_bvalid_m1 = sb_gnt[1] & sb_bvalid_s;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_sb_arb2.sv
// Directed bench for sb_arb2: reset, single read, contention, starvation/round-robin,
// back-pressure and same-master read-before-write ordering.
module tb_sb_arb2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;

  logic            sb_arvalid_m0, sb_arvalid_m1;
  logic [AW-1:0]   sb_araddr_m0, sb_araddr_m1;
  logic            sb_arready_m0, sb_arready_m1;
  logic            sb_rvalid_m0, sb_rvalid_m1;
  logic [DW-1:0]   sb_rdata_m0, sb_rdata_m1;
  logic            sb_rready_m0, sb_rready_m1;
  logic            sb_wvalid_m0, sb_wvalid_m1;
  logic [AW-1:0]   sb_waddr_m0, sb_waddr_m1;
  logic [DW-1:0]   sb_wdata_m0, sb_wdata_m1;
  logic [DW/8-1:0] sb_wstrb_m0, sb_wstrb_m1;
  logic            sb_wready_m0, sb_wready_m1;
  logic            sb_bvalid_m0, sb_bvalid_m1;
  logic            sb_bresp_m0, sb_bresp_m1;
  logic            sb_bready_m0, sb_bready_m1;
  logic            sb_arvalid_s;
  logic [AW-1:0]   sb_araddr_s;
  logic            sb_arready_s;
  logic            sb_rvalid_s;
  logic [DW-1:0]   sb_rdata_s;
  logic            sb_rready_s;
  logic            sb_wvalid_s;
  logic [AW-1:0]   sb_waddr_s;
  logic [DW-1:0]   sb_wdata_s;
  logic [DW/8-1:0] sb_wstrb_s;
  logic            sb_wready_s;
  logic            sb_bvalid_s;
  logic            sb_bresp_s;
  logic            sb_bready_s;
  logic [1:0]      sb_gnt;

  int total = 0;
  int bad   = 0;

  logic [11:0] vr;
  assign vr = {sb_arvalid_s, sb_rready_s, sb_wvalid_s, sb_bready_s,
               sb_arready_m0, sb_arready_m1, sb_rvalid_m0, sb_rvalid_m1,
               sb_wready_m0, sb_wready_m1, sb_bvalid_m0, sb_bvalid_m1};

  sb_arb2 #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .sb_arvalid_m0(sb_arvalid_m0), .sb_araddr_m0(sb_araddr_m0), .sb_arready_m0(sb_arready_m0),
    .sb_rvalid_m0(sb_rvalid_m0), .sb_rdata_m0(sb_rdata_m0), .sb_rready_m0(sb_rready_m0),
    .sb_wvalid_m0(sb_wvalid_m0), .sb_waddr_m0(sb_waddr_m0), .sb_wdata_m0(sb_wdata_m0),
    .sb_wstrb_m0(sb_wstrb_m0), .sb_wready_m0(sb_wready_m0),
    .sb_bvalid_m0(sb_bvalid_m0), .sb_bresp_m0(sb_bresp_m0), .sb_bready_m0(sb_bready_m0),
    .sb_arvalid_m1(sb_arvalid_m1), .sb_araddr_m1(sb_araddr_m1), .sb_arready_m1(sb_arready_m1),
    .sb_rvalid_m1(sb_rvalid_m1), .sb_rdata_m1(sb_rdata_m1), .sb_rready_m1(sb_rready_m1),
    .sb_wvalid_m1(sb_wvalid_m1), .sb_waddr_m1(sb_waddr_m1), .sb_wdata_m1(sb_wdata_m1),
    .sb_wstrb_m1(sb_wstrb_m1), .sb_wready_m1(sb_wready_m1),
    .sb_bvalid_m1(sb_bvalid_m1), .sb_bresp_m1(sb_bresp_m1), .sb_bready_m1(sb_bready_m1),
    .sb_arvalid_s(sb_arvalid_s), .sb_araddr_s(sb_araddr_s), .sb_arready_s(sb_arready_s),
    .sb_rvalid_s(sb_rvalid_s), .sb_rdata_s(sb_rdata_s), .sb_rready_s(sb_rready_s),
    .sb_wvalid_s(sb_wvalid_s), .sb_waddr_s(sb_waddr_s), .sb_wdata_s(sb_wdata_s),
    .sb_wstrb_s(sb_wstrb_s), .sb_wready_s(sb_wready_s),
    .sb_bvalid_s(sb_bvalid_s), .sb_bresp_s(sb_bresp_s), .sb_bready_s(sb_bready_s),
    .sb_gnt(sb_gnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    sb_arvalid_m0 = 0; sb_araddr_m0 = '0; sb_rready_m0 = 0;
    sb_wvalid_m0 = 0; sb_waddr_m0 = '0; sb_wdata_m0 = '0; sb_wstrb_m0 = '0; sb_bready_m0 = 0;
    sb_arvalid_m1 = 0; sb_araddr_m1 = '0; sb_rready_m1 = 0;
    sb_wvalid_m1 = 0; sb_waddr_m1 = '0; sb_wdata_m1 = '0; sb_wstrb_m1 = '0; sb_bready_m1 = 0;
    sb_arready_s = 0; sb_rvalid_s = 0; sb_rdata_s = '0;
    sb_wready_s = 0; sb_bvalid_s = 0; sb_bresp_s = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    // initial reset with slave readies/valids high: outputs must still be quiet
    clear_inputs();
    sb_arready_s = 1; sb_rvalid_s = 1; sb_wready_s = 1; sb_bvalid_s = 1;
    rst = 1;
    tick();
    #1;
    total++; if (sb_gnt !== 2'b00) begin bad++; $display("FAIL rst_gnt got=%b exp=00", sb_gnt); end
    total++; if (vr !== 12'h000) begin bad++; $display("FAIL rst_vr got=%h exp=000", vr); end
    // reset in the middle of R
    do_reset();
    sb_arvalid_m0 = 1; sb_araddr_m0 = 32'h1000; sb_arready_s = 1;
    tick();  // -> AR
    tick();  // -> R
    sb_arvalid_m0 = 0; sb_arready_s = 0; sb_rready_m0 = 0; sb_rvalid_s = 1;
    #1;
    total++; if (sb_rvalid_m0 !== 1'b1) begin bad++; $display("FAIL rst_in_r got=%b exp=1", sb_rvalid_m0); end
    rst = 1; sb_rready_m0 = 1; sb_arready_s = 1; sb_wready_s = 1; sb_bvalid_s = 1;
    sb_bready_m0 = 1; sb_rready_m1 = 1; sb_bready_m1 = 1;
    tick();
    #1;
    total++; if (sb_gnt !== 2'b00) begin bad++; $display("FAIL rst_mid_gnt got=%b exp=00", sb_gnt); end
    total++; if (vr !== 12'h000) begin bad++; $display("FAIL rst_mid_vr got=%h exp=000", vr); end
    rst = 0;
    clear_inputs();
    sb_arvalid_m1 = 1; sb_araddr_m1 = 32'h5000;
    tick();  // -> AR for m1
    #1;
    total++; if (sb_gnt !== 2'b10) begin bad++; $display("FAIL rst_post_gnt got=%b exp=10", sb_gnt); end
    total++; if (sb_araddr_s !== 32'h5000 || sb_arvalid_s !== 1'b1)
      begin bad++; $display("FAIL rst_post_ar got=%h/%b exp=00005000/1", sb_araddr_s, sb_arvalid_s); end
  endtask

  task automatic test_single_read();
    do_reset();
    sb_arvalid_m0 = 1; sb_araddr_m0 = 32'h0000_1000; sb_rready_m0 = 1;
    tick();  // IDLE -> AR
    #1;
    total++; if (sb_arvalid_s !== 1'b1) begin bad++; $display("FAIL rd_arvalid got=%b exp=1", sb_arvalid_s); end
    total++; if (sb_araddr_s !== 32'h1000) begin bad++; $display("FAIL rd_araddr got=%h exp=00001000", sb_araddr_s); end
    total++; if (sb_gnt !== 2'b01) begin bad++; $display("FAIL rd_gnt got=%b exp=01", sb_gnt); end
    total++; if (sb_arready_m0 !== 1'b0) begin bad++; $display("FAIL rd_arready_lo got=%b exp=0", sb_arready_m0); end
    sb_arready_s = 1;
    #1;
    total++; if ({sb_arready_m0, sb_arready_m1} !== 2'b10)
      begin bad++; $display("FAIL rd_arready got=%b exp=10", {sb_arready_m0, sb_arready_m1}); end
    tick();  // -> R
    sb_arvalid_m0 = 0; sb_arready_s = 0;
    #1;
    total++; if (sb_arvalid_s !== 1'b0 || sb_araddr_s !== 32'h0)
      begin bad++; $display("FAIL rd_ar_quiet got=%b/%h exp=0/00000000", sb_arvalid_s, sb_araddr_s); end
    tick();  // R, slave still waiting
    sb_rvalid_s = 1; sb_rdata_s = 32'hDEAD_BEEF;
    #1;
    total++; if (sb_rvalid_m0 !== 1'b1 || sb_rdata_m0 !== 32'hDEAD_BEEF)
      begin bad++; $display("FAIL rd_rdata got=%b/%h exp=1/deadbeef", sb_rvalid_m0, sb_rdata_m0); end
    total++; if (sb_rvalid_m1 !== 1'b0) begin bad++; $display("FAIL rd_rvalid_m1 got=%b exp=0", sb_rvalid_m1); end
    total++; if (sb_rready_s !== 1'b1) begin bad++; $display("FAIL rd_rready_s got=%b exp=1", sb_rready_s); end
    tick();  // -> IDLE
    sb_rvalid_s = 0;
    #1;
    total++; if (sb_gnt !== 2'b00) begin bad++; $display("FAIL rd_done_gnt got=%b exp=00", sb_gnt); end
  endtask

  task automatic test_contention();
    do_reset();
    sb_arvalid_m0 = 1; sb_araddr_m0 = 32'h1000; sb_rready_m0 = 1;
    sb_wvalid_m1 = 1; sb_waddr_m1 = 32'h2000; sb_wdata_m1 = 32'h1234_5678; sb_wstrb_m1 = 4'hF;
    sb_bready_m1 = 1; sb_arready_s = 1;
    tick();  // -> AR m0
    #1;
    total++; if (sb_gnt !== 2'b01) begin bad++; $display("FAIL ct_gnt0 got=%b exp=01", sb_gnt); end
    tick();  // -> R
    sb_arvalid_m0 = 0; sb_arready_s = 0; sb_rvalid_s = 1;
    #1;
    total++; if (sb_wvalid_s !== 1'b0) begin bad++; $display("FAIL ct_w_blocked got=%b exp=0", sb_wvalid_s); end
    tick();  // -> IDLE (bubble)
    sb_rvalid_s = 0;
    #1;
    total++; if (sb_gnt !== 2'b00 || sb_wvalid_s !== 1'b0)
      begin bad++; $display("FAIL ct_bubble got=%b/%b exp=00/0", sb_gnt, sb_wvalid_s); end
    tick();  // -> W m1
    #1;
    total++; if (sb_gnt !== 2'b10) begin bad++; $display("FAIL ct_gnt1 got=%b exp=10", sb_gnt); end
    total++; if ({sb_wvalid_s, sb_waddr_s, sb_wdata_s, sb_wstrb_s} !== {1'b1, 32'h2000, 32'h1234_5678, 4'hF})
      begin bad++; $display("FAIL ct_wr got=%b/%h/%h/%h exp=1/00002000/12345678/f",
                            sb_wvalid_s, sb_waddr_s, sb_wdata_s, sb_wstrb_s); end
    sb_wready_s = 1;
    #1;
    total++; if ({sb_wready_m0, sb_wready_m1} !== 2'b01)
      begin bad++; $display("FAIL ct_wready got=%b exp=01", {sb_wready_m0, sb_wready_m1}); end
    tick();  // -> B
    sb_wvalid_m1 = 0; sb_wready_s = 0;
    #1;
    total++; if (sb_bvalid_m1 !== 1'b0 || sb_bready_s !== 1'b1)
      begin bad++; $display("FAIL ct_b_wait got=%b/%b exp=0/1", sb_bvalid_m1, sb_bready_s); end
    sb_bvalid_s = 1; sb_bresp_s = 1;
    #1;
    total++; if ({sb_bvalid_m0, sb_bvalid_m1, sb_bresp_m1} !== 3'b011)
      begin bad++; $display("FAIL ct_bresp got=%b exp=011", {sb_bvalid_m0, sb_bvalid_m1, sb_bresp_m1}); end
    tick();  // -> IDLE
    sb_bvalid_s = 0; sb_bresp_s = 0;
    #1;
    total++; if (sb_gnt !== 2'b00) begin bad++; $display("FAIL ct_done_gnt got=%b exp=00", sb_gnt); end
  endtask

  task automatic test_starve();
    logic [1:0] exp_seq [4];
`ifdef SB_ARB_RR_EN
    exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    do_reset();
    sb_arvalid_m0 = 1; sb_araddr_m0 = 32'h1000; sb_rready_m0 = 1;
    sb_arvalid_m1 = 1; sb_araddr_m1 = 32'h3000; sb_rready_m1 = 1;
    sb_arready_s = 1; sb_rvalid_s = 1;
    for (int g = 0; g < 4; g++) begin
      tick();  // IDLE -> AR
      #1;
      total++; if (sb_gnt !== exp_seq[g])
        begin bad++; $display("FAIL arb_gnt%0d got=%b exp=%b", g, sb_gnt, exp_seq[g]); end
      tick();  // AR -> R
      tick();  // R -> IDLE
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    sb_arvalid_m0 = 1; sb_araddr_m0 = 32'h1000; sb_arready_s = 1;
    tick();  // -> AR
    tick();  // -> R
    sb_arvalid_m0 = 0; sb_arready_s = 0; sb_rvalid_s = 1; sb_rready_m0 = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if ({sb_rready_s, sb_gnt, sb_rvalid_m0} !== 4'b0011)
        begin bad++; $display("FAIL bp_hold%0d got=%b exp=0011", c, {sb_rready_s, sb_gnt, sb_rvalid_m0}); end
      tick();
    end
    sb_rready_m0 = 1;
    #1;
    total++; if (sb_rready_s !== 1'b1) begin bad++; $display("FAIL bp_rready got=%b exp=1", sb_rready_s); end
    tick();  // handshake -> IDLE
    sb_rvalid_s = 0;
    #1;
    total++; if (sb_gnt !== 2'b00) begin bad++; $display("FAIL bp_done_gnt got=%b exp=00", sb_gnt); end
  endtask

  task automatic test_back_to_back();
    // m1 offers read and write together: read runs first, write follows
    do_reset();
    sb_arvalid_m1 = 1; sb_araddr_m1 = 32'h3000; sb_rready_m1 = 1;
    sb_wvalid_m1 = 1; sb_waddr_m1 = 32'h4000; sb_wdata_m1 = 32'hAAAA_5555; sb_wstrb_m1 = 4'h3;
    sb_bready_m1 = 1; sb_arready_s = 1;
    tick();  // -> AR
    #1;
    total++; if ({sb_gnt, sb_arvalid_s, sb_wvalid_s} !== 4'b1010 || sb_araddr_s !== 32'h3000)
      begin bad++; $display("FAIL ord_ar got=%b/%h exp=1010/00003000", {sb_gnt, sb_arvalid_s, sb_wvalid_s}, sb_araddr_s); end
    tick();  // -> R
    sb_arvalid_m1 = 0; sb_arready_s = 0; sb_rvalid_s = 1;
    #1;
    total++; if (sb_rvalid_m1 !== 1'b1) begin bad++; $display("FAIL ord_r got=%b exp=1", sb_rvalid_m1); end
    tick();  // -> IDLE
    sb_rvalid_s = 0;
    tick();  // -> W
    #1;
    total++; if ({sb_gnt, sb_wvalid_s} !== 3'b101 || sb_waddr_s !== 32'h4000 || sb_wstrb_s !== 4'h3)
      begin bad++; $display("FAIL ord_w got=%b/%h/%h exp=101/00004000/3", {sb_gnt, sb_wvalid_s}, sb_waddr_s, sb_wstrb_s); end
    sb_wready_s = 1;
    tick();  // -> B
    sb_wvalid_m1 = 0; sb_wready_s = 0; sb_bvalid_s = 1;
    #1;
    total++; if (sb_bvalid_m1 !== 1'b1) begin bad++; $display("FAIL ord_b got=%b exp=1", sb_bvalid_m1); end
    tick();  // -> IDLE
    sb_bvalid_s = 0;
    #1;
    total++; if (sb_gnt !== 2'b00) begin bad++; $display("FAIL ord_done got=%b exp=00", sb_gnt); end
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_contention();
    test_starve();
    test_backpressure();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
